// File: rtl/remap_pkg.sv
// Shared types for the register remap unit: op encoding and identity-table helper.
// Imported by remap_ckpt_stack and register_remap_unit.
package remap_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_SWAP    = 3'd1,
        OP_ROTATE  = 3'd2,
        OP_IDENT   = 3'd3,
        OP_SAVE    = 3'd4,
        OP_RESTORE = 3'd5
    } remap_op_e;

    // Upper bound on a flattened table; callers truncate to their own width.
    localparam int unsigned MAX_TBL_W = 4096;

    // Flattened identity table: entry i (w bits wide) holds the value i.
    function automatic logic [MAX_TBL_W-1:0] ident_table(
        input int unsigned n,
        input int unsigned w
    );
        logic [MAX_TBL_W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < n; i++) begin
            for (int unsigned b = 0; b < w; b++) begin
                t[i*w+b] = i[b];
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/remap_ckpt_stack.sv
// LIFO of whole remap tables (DEPTH entries of WIDTH bits).
// Ports: push/push_data, pop/top_data, count, full, empty; sync active-low reset.
module remap_ckpt_stack
    import remap_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign wr_ptr   = PTR_W'(count_q);
    assign rd_ptr   = PTR_W'(count_q - CNT_W'(1));
    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Garbage while empty; the owner never pops an empty stack.
    assign top_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (push && !full) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/register_remap_unit.sv
// Logical-to-physical register remapper: permutation table with SWAP/ROTATE/IDENT
// and an optional checkpoint stack (built only when REMAP_CKPT_EN is defined).
// Ports: rd_a/rd_b/wr idx->phys lookups, op_valid/op/op_a/op_b, ckpt_count/full/empty, err.
module register_remap_unit
    import remap_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int CKPT_DEPTH = 2,
    localparam int IDX_W = $clog2(NUM_REGS),
    localparam int CNT_W = $clog2(CKPT_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_a_idx,
    input  logic [IDX_W-1:0] rd_b_idx,
    input  logic [IDX_W-1:0] wr_idx,
    output logic [IDX_W-1:0] rd_a_phys,
    output logic [IDX_W-1:0] rd_b_phys,
    output logic [IDX_W-1:0] wr_phys,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [IDX_W-1:0] op_a,
    input  logic [IDX_W-1:0] op_b,
    output logic [CNT_W-1:0] ckpt_count,
    output logic             ckpt_full,
    output logic             ckpt_empty,
    output logic             err
);

    localparam int TBL_W = NUM_REGS * IDX_W;
    localparam logic [TBL_W-1:0] IDENT_TBL = TBL_W'(ident_table(NUM_REGS, IDX_W));

    logic [NUM_REGS-1:0][IDX_W-1:0] map_q;
    logic [NUM_REGS-1:0][IDX_W-1:0] map_d;
    logic err_q;
    logic err_d;

    assign rd_a_phys = map_q[rd_a_idx];
    assign rd_b_phys = map_q[rd_b_idx];
    assign wr_phys   = map_q[wr_idx];
    assign err       = err_q;

`ifdef REMAP_CKPT_EN
    logic             push;
    logic             pop;
    logic [TBL_W-1:0] top_data;

    remap_ckpt_stack #(
        .DEPTH (CKPT_DEPTH),
        .WIDTH (TBL_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (map_q),
        .top_data  (top_data),
        .count     (ckpt_count),
        .full      (ckpt_full),
        .empty     (ckpt_empty)
    );
`else
    assign ckpt_count = '0;
    assign ckpt_full  = 1'b1;
    assign ckpt_empty = 1'b1;
`endif

    always_comb begin
        map_d = map_q;
        err_d = 1'b0;
`ifdef REMAP_CKPT_EN
        push  = 1'b0;
        pop   = 1'b0;
`endif
        if (op_valid) begin
            case (op)
                OP_NOP: ;
                // Equal operands write the same value back: table unchanged.
                OP_SWAP: begin
                    map_d[op_a] = map_q[op_b];
                    map_d[op_b] = map_q[op_a];
                end
                // new[i] = old[i+1], new[top] = old[0]
                OP_ROTATE: map_d = {map_q[0], map_q[NUM_REGS-1:1]};
                OP_IDENT:  map_d = IDENT_TBL;
`ifdef REMAP_CKPT_EN
                OP_SAVE: begin
                    if (ckpt_full) err_d = 1'b1;
                    else           push  = 1'b1;
                end
                OP_RESTORE: begin
                    if (ckpt_empty) begin
                        err_d = 1'b1;
                    end else begin
                        pop   = 1'b1;
                        map_d = top_data;
                    end
                end
`endif
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            map_q <= IDENT_TBL;
            err_q <= 1'b0;
        end else begin
            map_q <= map_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_register_remap_unit.sv
// Randomized self-checking bench for register_remap_unit against a table/queue model.
// Expectations follow REMAP_CKPT_EN (stack present or compiled out).
module tb_register_remap_unit;

    localparam int N  = 8;
    localparam int D  = 2;
    localparam int W  = 3;
    localparam int CW = $clog2(D + 1);
`ifdef REMAP_CKPT_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  rd_a_idx, rd_b_idx, wr_idx;
    logic [W-1:0]  rd_a_phys, rd_b_phys, wr_phys;
    logic          op_valid;
    logic [2:0]    op;
    logic [W-1:0]  op_a, op_b;
    logic [CW-1:0] ckpt_count;
    logic          ckpt_full, ckpt_empty, err;

    register_remap_unit #(
        .NUM_REGS   (N),
        .CKPT_DEPTH (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_a_idx   (rd_a_idx),
        .rd_b_idx   (rd_b_idx),
        .wr_idx     (wr_idx),
        .rd_a_phys  (rd_a_phys),
        .rd_b_phys  (rd_b_phys),
        .wr_phys    (wr_phys),
        .op_valid   (op_valid),
        .op         (op),
        .op_a       (op_a),
        .op_b       (op_b),
        .ckpt_count (ckpt_count),
        .ckpt_full  (ckpt_full),
        .ckpt_empty (ckpt_empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef int tbl_t [N];

    int   checks   = 0;
    int   failures = 0;
    tbl_t m;
    tbl_t stk [$];
    int   exp_err;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = i;
        stk.delete();
        exp_err = 0;
    endtask

    task automatic model_apply(input int o, input int a, input int b, input bit v);
        tbl_t t;
        exp_err = 0;
        if (v) begin
            case (o)
                0: ;
                1: begin
                    int x;
                    x = m[a]; m[a] = m[b]; m[b] = x;
                end
                2: begin
                    t = m;
                    for (int i = 0; i < N; i++) m[i] = t[(i + 1) % N];
                end
                3: for (int i = 0; i < N; i++) m[i] = i;
                4: if (CK && stk.size() < D) stk.push_back(m);
                   else exp_err = 1;
                5: if (CK && stk.size() > 0) m = stk.pop_back();
                   else exp_err = 1;
                default: exp_err = 1;
            endcase
        end
    endtask

    task automatic check_outs(input string tag);
        int sz;
        sz = stk.size();
        chk({tag, "_a"},     int'(rd_a_phys), m[rd_a_idx]);
        chk({tag, "_b"},     int'(rd_b_phys), m[rd_b_idx]);
        chk({tag, "_w"},     int'(wr_phys),   m[wr_idx]);
        chk({tag, "_err"},   int'(err),       exp_err);
        chk({tag, "_cnt"},   int'(ckpt_count), sz);
        chk({tag, "_empty"}, int'(ckpt_empty), CK ? int'(sz == 0) : 1);
        chk({tag, "_full"},  int'(ckpt_full),  CK ? int'(sz == D) : 1);
    endtask

    task automatic do_op(input int o, input int a, input int b, input bit v,
                         input int ra, input int rb, input int rw);
        @(negedge clk);
        op       = 3'(o);
        op_a     = W'(a);
        op_b     = W'(b);
        op_valid = v;
        rd_a_idx = W'(ra);
        rd_b_idx = W'(rb);
        wr_idx   = W'(rw);
        #1;
        chk("nobypass", int'(rd_a_phys), m[ra]);
        @(posedge clk);
        #1;
        model_apply(o, a, b, v);
        check_outs("post");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            rd_a_idx = W'(i);
            #1;
            chk("rst_map", int'(rd_a_phys), i);
        end
        chk("rst_cnt", int'(ckpt_count), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        op_valid = 1'b0;
        op       = '0;
        op_a     = '0;
        op_b     = '0;
        rd_a_idx = '0;
        rd_b_idx = '0;
        wr_idx   = '0;
        model_reset();

        do_reset();
        rd_a_idx = 3'd2;
        #1;
        chk("rst_rd2", int'(rd_a_phys), 2);

        // SWAP(1,3); the op cycle itself still reads 1 -> 1.
        do_op(1, 1, 3, 1'b1, 1, 3, 0);
        chk("swap_1", int'(rd_a_phys), 3);
        chk("swap_3", int'(rd_b_phys), 1);
        chk("swap_0", int'(wr_phys), 0);
        do_op(1, 1, 1, 1'b1, 1, 3, 0);
        chk("swap_same", int'(rd_a_phys), 3);
        chk("swap_same_err", int'(err), 0);

        // Wrap-around after two rotations of identity.
        do_op(3, 0, 0, 1'b1, 0, 0, 0);
        do_op(2, 0, 0, 1'b1, 6, 7, 0);
        do_op(2, 0, 0, 1'b1, 6, 7, 0);
        chk("rot_6", int'(rd_a_phys), 0);
        chk("rot_7", int'(rd_b_phys), 1);
        chk("rot_0", int'(wr_phys), 2);

        // Checkpoint sequence from identity.
        do_op(3, 0, 0, 1'b1, 0, 1, 2);
        do_op(1, 0, 1, 1'b1, 0, 1, 2);
        do_op(4, 0, 0, 1'b1, 0, 1, 2);
        chk("save1_err", int'(err), CK ? 0 : 1);
        do_op(2, 0, 0, 1'b1, 0, 1, 7);
        do_op(4, 0, 0, 1'b1, 0, 1, 7);
        do_op(4, 0, 0, 1'b1, 0, 1, 7);
        chk("save3_err", int'(err), 1);
        chk("save3_cnt", int'(ckpt_count), CK ? 2 : 0);
        do_op(5, 0, 0, 1'b1, 0, 1, 7);
        chk("rest1_a", int'(rd_a_phys), 0);
        chk("rest1_w", int'(wr_phys), 1);
        do_op(5, 0, 0, 1'b1, 0, 1, 7);
        chk("rest2_a", int'(rd_a_phys), CK ? 1 : 0);
        do_op(5, 0, 0, 1'b1, 0, 1, 7);
        chk("rest3_err", int'(err), 1);
        chk("rest3_cnt", int'(ckpt_count), 0);

        // Illegal encodings and an unqualified op.
        do_op(7, 0, 0, 1'b1, 0, 1, 2);
        chk("op7_err", int'(err), 1);
        do_op(6, 0, 0, 1'b1, 0, 1, 2);
        do_op(7, 0, 0, 1'b0, 0, 1, 2);
        chk("inval_err", int'(err), 0);

        // Reset in the cycle after a SAVE wins over a new op.
        do_reset();
        do_op(1, 2, 5, 1'b1, 2, 5, 0);
        do_op(4, 0, 0, 1'b1, 2, 5, 0);
        @(negedge clk);
        reset    = 1'b0;
        op       = 3'd4;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_a", int'(rd_a_phys), 2);
        chk("mid_rst_b", int'(rd_b_phys), 5);
        chk("mid_rst_cnt", int'(ckpt_count), 0);
        chk("mid_rst_err", int'(err), 0);
        model_reset();
        @(negedge clk);
        reset    = 1'b1;
        op_valid = 1'b0;

        for (int k = 0; k < 600; k++) begin
            do_op($urandom_range(0, 7), $urandom_range(0, N - 1),
                  $urandom_range(0, N - 1), ($urandom_range(0, 9) != 0),
                  $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                  $urandom_range(0, N - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_remap_unit.md
# register_remap_unit

Parametrised logical-to-physical register remapper for the processor's register-access path. It keeps a permutation table of NUM_REGS entries that is updated by SWAP, ROTATE and identity-reset operations. An optional checkpoint stack saves and restores the whole table. Decode indexes the unit with logical register fields and drives the physical indices into the register file.

## Interface
Parameters:
- NUM_REGS, 4: logical/physical register count; power of two, at least 2.
- CKPT_DEPTH, 2: checkpoint stack depth, at least 1; ignored when checkpointing is compiled out.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- rd_a_idx, rd_b_idx, wr_idx  in  IDX_W each  logical indices to translate; IDX_W = $clog2(NUM_REGS).
- rd_a_phys, rd_b_phys, wr_phys  out  IDX_W each  physical indices (combinational from the current table).
- op_valid  in  1  qualifies op for this cycle.
- op  in  3  remap_op_e: NOP, SWAP, ROTATE, IDENT, SAVE, RESTORE.
- op_a, op_b  in  IDX_W each  SWAP operands (logical indices).
- ckpt_count  out  $clog2(CKPT_DEPTH+1)  number of saved tables.
- ckpt_full, ckpt_empty  out  1  stack status (combinational from ckpt_count).
- err  out  1  registered one-cycle pulse for an illegal op.

## Operation
- Table state map[i] for i in 0..NUM_REGS-1. Reset value is identity: map[i]=i, ckpt_count=0, err=0.
- Translation: rd_a_phys=map[rd_a_idx], and likewise for rd_b and wr. All three are read from the registered table with no bypass of a same-cycle op.
- Ops are applied only when op_valid=1. An op with op_valid=0 is a NOP.
- SWAP: next map[op_a]=map[op_b] and next map[op_b]=map[op_a]. If op_a==op_b, the table is unchanged and err stays 0.
- ROTATE: next map[i]=map[(i+1) mod NUM_REGS] for all i, wrapping at the top index.
- IDENT: next table is identity. The stack is untouched.
- SAVE: pushes the current table and increments ckpt_count. If ckpt_full, nothing changes and err pulses.
- RESTORE: pops the top entry into the table and decrements ckpt_count. If ckpt_empty, nothing changes and err pulses.
- Undefined op encodings (6, 7): no state change, err pulses.
- The table is a permutation at all times. Every op preserves this property.
- Reset during any op: reset wins. The table goes to identity and the stack is emptied (count=0, contents don't-care).

## Timing
- Ops are single-cycle. A table or stack change is visible on the *_phys outputs in the cycle after the op is presented.
- Back-to-back ops on consecutive cycles are legal, and each sees the result of the previous one.
- err is asserted in cycle N+1 for an illegal op in cycle N and is low otherwise.
- ckpt_count updates in the same edge as the table.
- There is no handshake. The unit always accepts an op.

## Configuration
- REMAP_CKPT_EN defined: the checkpoint stack is built, and SAVE/RESTORE behave as above.
- REMAP_CKPT_EN undefined: no stack storage is built, ckpt_count is tied to 0, ckpt_empty=1 and ckpt_full=1. SAVE and RESTORE are treated as illegal: no state change, err pulses.

## Structure
- Package remap_pkg holds:
  - the remap_op_e enum (NOP=0, SWAP=1, ROTATE=2, IDENT=3, SAVE=4, RESTORE=5);
  - an identity-table helper function.
- The package does not contain IDX_W, because it depends on the module parameter.
- Sub-module remap_ckpt_stack is a LIFO of CKPT_DEPTH entries, each NUM_REGS*IDX_W bits wide, with push/pop/count/full/empty. It is instantiated only under REMAP_CKPT_EN.

## Test plan
- Reset check: hold reset=0 for 2 cycles, release. Expect map identity (rd_a_idx=2 gives rd_a_phys=2), ckpt_count=0, err=0.
- SWAP: NUM_REGS=4, SWAP(1,3), then SWAP(1,1).
  - After the first: rd 1->3, rd 3->1, rd 0->0.
  - The second leaves the table unchanged with err=0.
  - In the SWAP cycle itself, rd 1 still returns 1.
- Wrap-around: NUM_REGS=8, two ROTATE ops. Expect map[6]=0, map[7]=1, map[0]=2.
- Checkpoint: CKPT_DEPTH=2, sequence SWAP(0,1), SAVE, ROTATE, SAVE, SAVE, RESTORE, RESTORE, RESTORE.
  - Third SAVE pulses err with count staying 2.
  - First RESTORE gives the rotated table; second gives the table with 0 and 1 swapped.
  - Third RESTORE pulses err with count=0.
- Mid-operation reset: SAVE with count=1, then assert reset in the next cycle. Expect identity table, count=0, err=0.
- Macro off: build without REMAP_CKPT_EN, issue SAVE. Expect err pulse, table unchanged, ckpt_empty=1. Also issue op=7 and expect err pulse.
